// File: rtl/axil_regbank_gen2.sv
// AXI4-Lite register bank: N_REGS RW control registers, N_STATUS RO status registers, per-register write pulses.
// Define AXIL_REGBANK_IRQ_EN to add IRQ_STAT (W1C, sticky) and IRQ_MASK after the status block.
module axil_regbank_gen2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int N_REGS     = 8,
  parameter int N_STATUS   = 4,
  localparam int STAT_W    = (N_STATUS > 0 ? N_STATUS : 1) * DATA_WIDTH
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [N_REGS*DATA_WIDTH-1:0]   reg_o,
  output logic [N_REGS-1:0]              wr_pulse_o,
  input  logic [STAT_W-1:0]              status_i,
  input  logic [DATA_WIDTH-1:0]          irq_src_i,
  output logic                           irq_o
);

  localparam int ADDR_LSB     = $clog2(DATA_WIDTH/8);
  localparam int IDX_W        = ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W       = DATA_WIDTH/8;
  localparam int IRQ_STAT_IDX = N_REGS + N_STATUS;
  localparam int IRQ_MASK_IDX = N_REGS + N_STATUS + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_state_nx;
  rd_state_t rd_state, rd_state_nx;

  logic                    alive;
  logic                    aw_done, w_done, wr_fire, wr_ok;
  logic [IDX_W-1:0]        aw_idx_q, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   wdata_q, wr_data, rd_val;
  logic [STRB_W-1:0]       wstrb_q, wr_strb;
  logic                    ar_hs, rd_ok;
  logic [DATA_WIDTH-1:0]   regs [N_REGS];
  logic                    unused_ok;

  function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0] cur,
                                                       input logic [DATA_WIDTH-1:0] wd,
                                                       input logic [STRB_W-1:0] st);
    apply_strb = cur;
    for (int b = 0; b < STRB_W; b++)
      if (st[b]) apply_strb[b*8 +: 8] = wd[b*8 +: 8];
  endfunction

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) alive <= 1'b0;
    else                alive <= 1'b1;

  assign wr_idx  = aw_done ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_done  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb = w_done  ? wstrb_q  : S_AXI_WSTRB;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) wr_state <= WR_IDLE;
    else                wr_state <= wr_state_nx;

  always_comb begin
    wr_state_nx   = wr_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    wr_fire       = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        S_AXI_AWREADY = alive && !aw_done;
        S_AXI_WREADY  = alive && !w_done;
        wr_fire = (aw_done || (S_AXI_AWVALID && S_AXI_AWREADY)) &&
                  (w_done  || (S_AXI_WVALID  && S_AXI_WREADY));
        if (wr_fire) wr_state_nx = WR_RESP;
      end
      WR_RESP: if (S_AXI_BREADY) wr_state_nx = WR_IDLE;
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  assign S_AXI_BVALID = (wr_state == WR_RESP);

  always_comb begin
    wr_ok = 32'(wr_idx) < N_REGS;
`ifdef AXIL_REGBANK_IRQ_EN
    if (32'(wr_idx) == IRQ_STAT_IDX || 32'(wr_idx) == IRQ_MASK_IDX) wr_ok = 1'b1;
`endif
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      wr_pulse_o  <= '0;
      for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (wr_fire) begin
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < N_REGS; k++)
          if (32'(wr_idx) == k) begin
            regs[k]       <= apply_strb(regs[k], wr_data, wr_strb);
            wr_pulse_o[k] <= 1'b1;
          end
      end else begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          aw_done  <= 1'b1;
          aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          w_done  <= 1'b1;
          wdata_q <= S_AXI_WDATA;
          wstrb_q <= S_AXI_WSTRB;
        end
      end
    end

  for (genvar k = 0; k < N_REGS; k++) begin : g_reg_out
    assign reg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

`ifdef AXIL_REGBANK_IRQ_EN
  logic [DATA_WIDTH-1:0] irq_stat, irq_mask, irq_clr;
  logic                  irq_q;

  assign irq_clr = (wr_fire && 32'(wr_idx) == IRQ_STAT_IDX) ? apply_strb('0, wr_data, wr_strb) : '0;

  // Sources are OR'd in after the clear so a simultaneous set wins.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      irq_stat <= '0;
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~irq_clr) | irq_src_i;
      if (wr_fire && 32'(wr_idx) == IRQ_MASK_IDX) irq_mask <= apply_strb(irq_mask, wr_data, wr_strb);
      irq_q <= |(irq_stat & irq_mask);
    end

  assign irq_o     = irq_q;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
  assign irq_o     = 1'b0;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0],
                       irq_src_i};
`endif

  assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_hs  = (rd_state == RD_IDLE) && alive && S_AXI_ARVALID;

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    for (int k = 0; k < N_REGS; k++)
      if (32'(rd_idx) == k) begin
        rd_val = regs[k];
        rd_ok  = 1'b1;
      end
    for (int k = 0; k < N_STATUS; k++)
      if (32'(rd_idx) == N_REGS + k) begin
        rd_val = status_i[k*DATA_WIDTH +: DATA_WIDTH];
        rd_ok  = 1'b1;
      end
`ifdef AXIL_REGBANK_IRQ_EN
    if (32'(rd_idx) == IRQ_STAT_IDX) begin
      rd_val = irq_stat;
      rd_ok  = 1'b1;
    end
    if (32'(rd_idx) == IRQ_MASK_IDX) begin
      rd_val = irq_mask;
      rd_ok  = 1'b1;
    end
`endif
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) rd_state <= RD_IDLE;
    else                rd_state <= rd_state_nx;

  always_comb begin
    rd_state_nx   = rd_state;
    S_AXI_ARREADY = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        S_AXI_ARREADY = alive;
        if (ar_hs) rd_state_nx = RD_RESP;
      end
      RD_RESP: if (S_AXI_RREADY) rd_state_nx = RD_IDLE;
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  assign S_AXI_RVALID = (rd_state == RD_RESP);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= rd_val;
      S_AXI_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end

endmodule
